// File: rtl/jtframe_ram_arb.sv
// Round-robin arbiter sharing one jtframe RAM port among N req/ack requesters.
// Define JTFRAME_RAMARB_CLR_EN to add the zero-fill sweep (CLEAR, busy, clr).
module jtframe_ram_arb #(
   parameter int DW = 8,
   parameter int AW = 10,
   parameter int N  = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    we,
   input  logic [N*AW-1:0] addr,
   input  logic [N*DW-1:0] din,
   output logic [N-1:0]    ack,
   output logic [DW-1:0]   dout,
   output logic            busy,
   input  logic            clr,
   output logic [AW-1:0]   ram_addr,
   output logic [DW-1:0]   ram_data,
   output logic            ram_we,
   output logic            ram_en,
   input  logic [DW-1:0]   ram_q
);
   localparam int GW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT, DONE, CLEAR
   } state_t;

`ifdef JTFRAME_RAMARB_CLR_EN
   localparam state_t RST_ST = CLEAR;
   logic          r_busy;
`else
   localparam state_t RST_ST = IDLE;
   logic          w_unused;
`endif

   state_t        r_state;
   logic [GW-1:0] r_ptr;
   logic [GW-1:0] r_gnt;
   logic [N-1:0]  r_ack;
   logic [DW-1:0] r_dout;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic          r_we;
   logic          r_en;

   logic          w_any;
   logic [GW-1:0] w_sel;
   logic [GW-1:0] w_idx;

   // Scan downward so the nearest set bit after r_ptr wins.
   always_comb begin
      w_any = 1'b0;
      w_sel = r_ptr;
      w_idx = '0;
      for (int k = N; k >= 1; k--) begin
         w_idx = GW'((int'(r_ptr) + k) % N);
         if (req[w_idx]) begin
            w_any = 1'b1;
            w_sel = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RST_ST;
         r_ptr   <= GW'(N-1);
         r_gnt   <= '0;
         r_ack   <= '0;
         r_dout  <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_we    <= 1'b0;
         r_en    <= 1'b0;
`ifdef JTFRAME_RAMARB_CLR_EN
         r_busy  <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
`ifdef JTFRAME_RAMARB_CLR_EN
               if (clr) begin
                  r_state <= CLEAR;
                  r_busy  <= 1'b1;
                  r_en    <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= '0;
                  r_data  <= '0;
               end else
`endif
               if (w_any) begin
                  r_addr  <= addr[int'(w_sel)*AW +: AW];
                  r_data  <= din[int'(w_sel)*DW +: DW];
                  r_we    <= we[w_sel];
                  r_en    <= 1'b1;
                  r_gnt   <= w_sel;
                  r_ptr   <= w_sel;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_en    <= 1'b0;
               r_we    <= 1'b0;
               r_state <= WAIT;
            end
            WAIT: begin
               r_dout  <= ram_q;
               r_ack   <= N'(1) << r_gnt;
               r_state <= DONE;
            end
            DONE: begin
               r_ack   <= '0;
               r_state <= IDLE;
            end
            CLEAR: begin
`ifdef JTFRAME_RAMARB_CLR_EN
               // First cycle after reset arms the sweep.
               if (!r_busy) begin
                  r_busy <= 1'b1;
                  r_en   <= 1'b1;
                  r_we   <= 1'b1;
                  r_addr <= '0;
                  r_data <= '0;
               end else if (&r_addr) begin
                  r_busy  <= 1'b0;
                  r_en    <= 1'b0;
                  r_we    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
`else
               r_state <= IDLE;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef JTFRAME_RAMARB_CLR_EN
   assign busy = r_busy;
`else
   assign busy     = 1'b0;
   assign w_unused = clr;
`endif

   assign ack      = r_ack;
   assign dout     = r_dout;
   assign ram_addr = r_addr;
   assign ram_data = r_data;
   assign ram_we   = r_we;
   assign ram_en   = r_en;

endmodule

// File: doc/jtframe_ram_arb.md
Name: jtframe_ram_arb

Overview:
- Round-robin arbiter and access sequencer that shares one port of a jtframe dual-clock RAM among N requesters.
- Each requester gets a req/ack handshake and issues one read or write at a time.
- The block drives the RAM port's address, data, write-enable and clock-enable, then returns the registered read word.
- It sits between CPU, DMA or video-fetch logic and one RAM port; the other RAM port stays free for an independent clock domain.

Parameters:
- DW, 8, data width; must match the RAM's dw.
- AW, 10, address width; must match the RAM's aw.
- N, 3, number of requesters, 2..8.

Ports:
- clk  in  1  system clock; also clocks the RAM port.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester access request, level.
- we  in  N  per-requester write flag; 1 = write, 0 = read.
- addr  in  N*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- din  in  N*DW  flattened write data; requester i uses bits [i*DW +: DW].
- ack  out  N  one-cycle completion pulse, one-hot.
- dout  out  DW  registered read data, shared by all requesters.
- busy  out  1  high while a clear sweep runs.
- clr  in  1  one-cycle pulse requesting a clear sweep.
- ram_addr  out  AW  to RAM address port.
- ram_data  out  DW  to RAM data port.
- ram_we  out  1  to RAM write enable.
- ram_en  out  1  to RAM clock enable.
- ram_q  in  DW  from RAM q; valid one cycle after ram_en.

Behaviour:
- Reset values:
  - ack=0, dout=0, busy=0, ram_we=0, ram_en=0, ram_addr=0, ram_data=0.
  - Round-robin pointer = N-1, so requester 0 has first priority.
  - state=IDLE, or CLEAR when the optional feature is compiled in.
- States: IDLE, ISSUE, WAIT, DONE, CLEAR.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from pointer+1 modulo N.
  - Register the granted requester's addr and din onto ram_addr and ram_data, set ram_we=we[g] and ram_en=1.
  - Store g and set pointer=g. Go to ISSUE.
- ISSUE: the RAM samples on this cycle's closing edge. Clear ram_en and ram_we to 0. Go to WAIT.
- WAIT: ram_q is valid. Register dout<=ram_q, also on writes, where it carries the old contents. Set ack[g]=1. Go to DONE.
- DONE:
  - ack[g] is high for exactly this cycle and dout is stable. No arbitration happens in this state. Clear ack. Go to IDLE.
  - dout holds its value until the next WAIT.
- Latency: req sampled in cycle 0 gives ack and dout in cycle 3. Peak throughput is one access per 4 cycles.
- Requester rules:
  - Hold req, we, addr and din stable until ack.
  - Drop req in the cycle after ack; a req still high in IDLE starts a new access.
  - Dropping req after grant does not abort the access; ack still pulses.
- Simultaneous requests: exactly one grant. Under continuous contention every requester is served within N accesses.
- clr: sampled only in IDLE and takes precedence over pending req. In other states it is ignored; no queueing.
- Asynchronous reset mid-access: all outputs return to reset values immediately and ram_we drops. Whether an in-flight write landed is undefined. No ack is issued.

Optional Feature:
- Macro: JTFRAME_RAMARB_CLR_EN.
- When defined:
  - CLEAR state drives ram_en=1, ram_we=1, ram_data=0, with ram_addr counting 0..2**AW-1, one address per cycle.
  - busy=1 throughout. At the last address go to IDLE with busy=0 and ram_we=0.
  - Entered after reset release and from IDLE on clr. req is ignored (no ack) during CLEAR.
  - AW=10 gives 1024 busy cycles.
- When undefined:
  - No CLEAR state and no counter. Reset goes straight to IDLE.
  - busy is tied to 0 and clr is ignored.

Test Plan:
- Write then read: req0 write addr 0x055 data 0xA5, then req0 read 0x055. ack[0] comes 3 cycles after each req; second dout=0xA5; ram_en is high for exactly one cycle per access.
- Contention: req0, req1 and req2 all held high from reset. Grants go 0,1,2,0,1,2; each ack is exactly 4 cycles apart.
- Fairness: req2 held continuously, req0 pulsed per access. Grants alternate 2,0,2,0; req2 never starves.
- Early drop: req1 read of 0x3FF dropped one cycle after grant. ack[1] still pulses in cycle 3 and no extra access is issued.
- Reset mid-write: rst_n low during ISSUE. ram_we=0, ack=0 and dout=0 immediately; after release the first grant goes to requester 0.
- With JTFRAME_RAMARB_CLR_EN and AW=4: preload 0xFF everywhere, pulse clr. busy stays high 16 cycles; reads of addresses 0..15 all return 0x00.
